fp16_normalize_pack: RTL and testbench

//  Back end of the fp16 adder path: takes the sign/magnitude/carry result of the adder, left- or right-normalizes it
//  (one bit per cycle), rounds to nearest-even and packs an IEEE-754 binary16 word. Sequential, valid/ready on both sides.

---
 rtl/fp16_normalize_pack_pkg.sv | 16 +
 rtl/fp16_normalize_pack_round_rne.sv | 37 +++
 rtl/fp16_normalize_pack.sv | 141 ++++++++++++++
 tb/tb_fp16_normalize_pack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fp16_normalize_pack_pkg.sv
// Shared widths and FSM state encoding for the fp16 normalize/round/pack back end.
package fp16_normalize_pack_pkg;

    localparam int FP_EXP_W  = 5;
    localparam int FP_FRAC_W = 10;
    localparam int FP_GRD_W  = 2;
    localparam int FP_MAG_W  = FP_FRAC_W + FP_GRD_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp16_normalize_pack_round_rne.sv
// Round-to-nearest-even of a normalized (or subnormal) magnitude.
// Takes {hidden, frac, guard, sticky} with its exponent and returns the rounded
// fraction, the adjusted exponent and the hidden bit after rounding.
module fp16_normalize_pack_round_rne
    import fp16_normalize_pack_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W,
    parameter int GRD_W  = FP_GRD_W,
    localparam int MAG_W = FRAC_W + GRD_W + 2
) (
    input  logic [MAG_W-2:0]        mag_nc,
    input  logic signed [EXP_W+1:0] exp_in,
    output logic [FRAC_W-1:0]       frac,
    output logic signed [EXP_W+1:0] exp_out,
    output logic                    hidden
);

    logic                inc_s;
    logic [FRAC_W+1:0]   sum_s;

    // Round up on guard when sticky is set or the kept lsb is odd; a carry past the hidden bit renormalizes.
    always_comb begin
        inc_s = mag_nc[1] & (mag_nc[0] | mag_nc[2]);
        sum_s = {1'b0, mag_nc[MAG_W-2:2]} + {{(FRAC_W+1){1'b0}}, inc_s};
        if (sum_s[FRAC_W+1]) begin
            frac    = {FRAC_W{1'b0}};
            exp_out = exp_in + {{(EXP_W+1){1'b0}}, 1'b1};
            hidden  = 1'b1;
        end else begin
            frac    = sum_s[FRAC_W-1:0];
            exp_out = exp_in;
            hidden  = sum_s[FRAC_W];
        end
    end

endmodule

// File: rtl/fp16_normalize_pack.sv
// fp16 adder back end: normalizes the adder magnitude one bit per cycle, rounds
// to nearest-even and packs a binary16 word, with valid/ready on both sides.
// Optional build macro FP16_PACK_FTZ_EN: subnormal results are flushed to signed zero.
module fp16_normalize_pack
    import fp16_normalize_pack_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W,
    parameter int GRD_W  = FP_GRD_W,
    localparam int MAG_W = FRAC_W + GRD_W + 2,
    localparam int RES_W = 1 + EXP_W + FRAC_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAG_W-1:0] i_magnitude,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [RES_W-1:0] o_result,
    output logic             o_overflow,
    output logic             o_underflow
);

    // Exponent is carried two bits wider than the field so it can exceed the
    // all-ones code after a carry shift plus a rounding carry without wrapping.
    localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};
    localparam logic signed [EXP_W+1:0] EXP_SAT = {2'b00, {EXP_W{1'b1}}};

    state_t                  state_r;
    logic                    sign_r;
    logic signed [EXP_W+1:0] exp_r;
    logic [MAG_W-1:0]        mag_r;

    logic                    mag_zero_s;
    logic [FRAC_W-1:0]       rnd_frac_s;
    logic signed [EXP_W+1:0] rnd_exp_s;
    logic                    rnd_hidden_s;
    logic [RES_W-1:0]        pack_res_s;
    logic                    pack_ovf_s;
    logic                    pack_unf_s;

    assign mag_zero_s = (mag_r == {MAG_W{1'b0}});

    fp16_normalize_pack_round_rne #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .GRD_W  (GRD_W)
    ) u_round (
        .mag_nc  (mag_r[MAG_W-2:0]),
        .exp_in  (exp_r),
        .frac    (rnd_frac_s),
        .exp_out (rnd_exp_s),
        .hidden  (rnd_hidden_s)
    );

    // Classify the rounded value (zero, overflow, subnormal, normal) and build the packed word.
    always_comb begin
        pack_res_s = {RES_W{1'b0}};
        pack_ovf_s = 1'b0;
        pack_unf_s = 1'b0;
        if (mag_zero_s) begin
            // Exact zero is always reported as +0.
            pack_res_s = {RES_W{1'b0}};
        end else if (rnd_exp_s >= EXP_SAT) begin
            pack_res_s = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            pack_ovf_s = 1'b1;
        end else if (!rnd_hidden_s) begin
`ifdef FP16_PACK_FTZ_EN
            pack_res_s = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
`else
            pack_res_s = {sign_r, {EXP_W{1'b0}}, rnd_frac_s};
`endif
            pack_unf_s = 1'b1;
        end else begin
            pack_res_s = {sign_r, rnd_exp_s[EXP_W-1:0], rnd_frac_s};
        end
    end

    // Control FSM with the normalizing shifter and registered handshake/result outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            sign_r      <= 1'b0;
            exp_r       <= {(EXP_W+2){1'b0}};
            mag_r       <= {MAG_W{1'b0}};
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_result    <= {RES_W{1'b0}};
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid && o_ready) begin
                        sign_r  <= i_sign;
                        exp_r   <= {2'b00, i_exp};
                        mag_r   <= i_magnitude;
                        o_ready <= 1'b0;
                        state_r <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (mag_r[MAG_W-1]) begin
                        // Carry set: shift right once, folding the dropped bit into sticky.
                        mag_r <= {1'b0, mag_r[MAG_W-1:2], mag_r[1] | mag_r[0]};
                        exp_r <= exp_r + EXP_ONE;
                    end else if (mag_r[MAG_W-2] || mag_zero_s || (exp_r == EXP_ONE)) begin
                        // Normalized, zero, or at the minimum exponent (subnormal): stop shifting.
                        state_r <= ST_ROUND;
                    end else begin
                        mag_r <= {mag_r[MAG_W-2:0], 1'b0};
                        exp_r <= exp_r - EXP_ONE;
                    end
                end
                ST_ROUND: begin
                    o_result    <= pack_res_s;
                    o_overflow  <= pack_ovf_s;
                    o_underflow <= pack_unf_s;
                    o_valid     <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Directed self-checking bench for fp16_normalize_pack: a vector table with
// hand-computed results and latencies, plus backpressure and mid-operation reset sequences.
module tb_fp16_normalize_pack;

`ifdef FP16_PACK_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sign = 1'b0;
    logic [4:0]  i_exp = 5'd0;
    logic [13:0] i_mag = 14'd0;
    logic        i_ready = 1'b0;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_result;
    logic        o_overflow;
    logic        o_underflow;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic        sign;
        logic [4:0]  exp;
        logic [13:0] mag;
        logic [15:0] res;
        logic        ovf;
        logic        unf;
        logic        chk_unf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    fp16_normalize_pack dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_magnitude (i_mag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic add_vec(input string name, input logic sign, input logic [4:0] e,
                           input logic [13:0] mag, input logic [15:0] res, input logic ovf,
                           input logic unf, input logic chk_unf, input int lat);
        vec_t v;
        v.name = name; v.sign = sign; v.exp = e; v.mag = mag; v.res = res;
        v.ovf = ovf; v.unf = unf; v.chk_unf = chk_unf; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        cyc = 0;
        while (!o_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        i_sign  = v.sign;
        i_exp   = v.exp;
        i_mag   = v.mag;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({v.name, " latency"}, cyc, v.lat);
        check({v.name, " result"}, {16'd0, o_result}, {16'd0, v.res});
        check({v.name, " overflow"}, {31'd0, o_overflow}, {31'd0, v.ovf});
        if (v.chk_unf) begin
            check({v.name, " underflow"}, {31'd0, o_underflow}, {31'd0, v.unf});
        end
        check({v.name, " ready low in done"}, {31'd0, o_ready}, 32'd0);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check({v.name, " valid drop"}, {31'd0, o_valid}, 32'd0);
        check({v.name, " ready back"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;

        add_vec("one",         1'b0, 5'd15, 14'h1000, 16'h3C00, 1'b0, 1'b0, 1'b1, 2);
        add_vec("two_carry",   1'b0, 5'd15, 14'h2000, 16'h4000, 1'b0, 1'b0, 1'b1, 3);
        add_vec("cancel10",    1'b0, 5'd15, 14'h0004, 16'h1400, 1'b0, 1'b0, 1'b1, 12);
        add_vec("cancel12",    1'b0, 5'd15, 14'h0001, 16'h0C00, 1'b0, 1'b0, 1'b1, 14);
        add_vec("rne_tie_ev",  1'b0, 5'd15, 14'h1002, 16'h3C00, 1'b0, 1'b0, 1'b1, 2);
        add_vec("rne_tie_odd", 1'b0, 5'd15, 14'h1006, 16'h3C02, 1'b0, 1'b0, 1'b1, 2);
        add_vec("rne_above",   1'b1, 5'd15, 14'h1003, 16'hBC01, 1'b0, 1'b0, 1'b1, 2);
        add_vec("sticky_set",  1'b0, 5'd15, 14'h2005, 16'h4001, 1'b0, 1'b0, 1'b1, 3);
        add_vec("sticky_clr",  1'b0, 5'd15, 14'h2004, 16'h4000, 1'b0, 1'b0, 1'b1, 3);
        add_vec("ovf_carry",   1'b0, 5'd30, 14'h2000, 16'h7C00, 1'b1, 1'b0, 1'b1, 3);
        add_vec("ovf_round",   1'b0, 5'd30, 14'h1FFE, 16'h7C00, 1'b1, 1'b0, 1'b1, 2);
        add_vec("ovf_neg",     1'b1, 5'd29, 14'h3FFF, 16'hFC00, 1'b1, 1'b0, 1'b1, 3);
        add_vec("subn_exp1",   1'b0, 5'd1,  14'h0800, FTZ ? 16'h0000 : 16'h0200, 1'b0, 1'b1, 1'b1, 2);
        add_vec("subn_shift",  1'b0, 5'd3,  14'h0100, FTZ ? 16'h0000 : 16'h0100, 1'b0, 1'b1, 1'b1, 4);
        add_vec("subn_neg",    1'b1, 5'd2,  14'h0400, FTZ ? 16'h8000 : 16'h8200, 1'b0, 1'b1, 1'b1, 3);
        add_vec("subn_to_nrm", 1'b0, 5'd1,  14'h0FFE, 16'h0400, 1'b0, 1'b0, 1'b1, 2);
        add_vec("subn_to_0",   1'b1, 5'd1,  14'h0002, 16'h8000, 1'b0, 1'b1, 1'b1, 2);
        add_vec("zero",        1'b1, 5'd7,  14'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst o_ready", {31'd0, o_ready}, 32'd1);
        check("rst o_valid", {31'd0, o_valid}, 32'd0);
        check("rst o_result", {16'd0, o_result}, 32'd0);
        check("rst o_overflow", {31'd0, o_overflow}, 32'd0);
        check("rst o_underflow", {31'd0, o_underflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held and new input ignored while in DONE
        i_sign = 1'b0; i_exp = 5'd15; i_mag = 14'h1006; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("bp latency", cyc, 32'd2);
        i_sign = 1'b1; i_exp = 5'd20; i_mag = 14'h2000; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp result hold", {16'd0, o_result}, 32'h3C02);
            check("bp valid hold", {31'd0, o_valid}, 32'd1);
            check("bp ready low", {31'd0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("bp release valid", {31'd0, o_valid}, 32'd0);
        check("bp release ready", {31'd0, o_ready}, 32'd1);
        run_vec(vecs[0]);

        // Reset during NORM drops the in-flight operation
        i_sign = 1'b0; i_exp = 5'd15; i_mag = 14'h0004; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid busy ready", {31'd0, o_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid rst valid", {31'd0, o_valid}, 32'd0);
        check("mid rst ready", {31'd0, o_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("mid rst no late valid", {31'd0, o_valid}, 32'd0);
        run_vec(vecs[5]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
